// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_add_mult_ctrl : start/done unsigned WIDTHxWIDTH -> 2*WIDTH multiplier |
// |                       iterating a single ripple adder, one bit per cycle.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+

module adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  always_comb begin : ripple
    logic carry;
    carry = carry_in;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    carry_out = carry;
  end

endmodule

module shift_add_mult_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("shift_add_mult_ctrl: WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               zero_q, zero_d;

  logic [WIDTH-1:0]   adder_b;
  logic [WIDTH-1:0]   adder_sum;
  logic               adder_carry;
  logic [2*WIDTH-1:0] next_acc;

  assign adder_b = acc_lo_q[0] ? mcand_q : '0;

  adder #(.WIDTH(WIDTH)) u_adder (
    .a        (acc_hi_q),
    .b        (adder_b),
    .carry_in (1'b0),
    .sum      (adder_sum),
    .carry_out(adder_carry)
  );

  // Carry becomes the new MSB so the final iteration never loses a bit.
  assign next_acc = {adder_carry, adder_sum, acc_lo_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    count_d   = count_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    zero_d    = zero_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (start) begin
          mcand_d  = multiplicand;
          acc_hi_d = '0;
          acc_lo_d = multiplier;
          count_d  = '0;
          state_d  = ST_BUSY;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end
      ST_BUSY: begin
        {acc_hi_d, acc_lo_d} = next_acc;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_COUNT) begin
          state_d   = ST_DONE;
          ready_d   = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          product_d = next_acc;
          zero_d    = ~|next_acc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      zero_q    <= zero_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign zero    = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// Bench for shift_add_mult_ctrl: table vectors, random operands vs. arithmetic model,
// and hand sequences for back-to-back, busy-start and mid-operation reset (WIDTH=64 and 4).
module tb_shift_add_mult_ctrl;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [63:0]  multiplicand = '0;
  logic [63:0]  multiplier = '0;
  logic         ready, busy, done, zero;
  logic [127:0] product;

  logic         start4 = 1'b0;
  logic [3:0]   mcand4 = '0;
  logic [3:0]   mplier4 = '0;
  logic         ready4, busy4, done4, zero4;
  logic [7:0]   product4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.WIDTH(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .ready(ready), .busy(busy), .done(done), .product(product), .zero(zero)
  );

  shift_add_mult_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4),
    .multiplicand(mcand4), .multiplier(mplier4),
    .ready(ready4), .busy(busy4), .done(done4), .product(product4), .zero(zero4)
  );

  typedef struct {
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] p;
    bit           poke;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] wa, wb;
    wa = {64'd0, a};
    wb = {64'd0, b};
    return wa * wb;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    bit ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (ready) ok = 1;
      else tick();
    end
    check({name, "_ready_timeout"}, 128'(ok), 128'd1);
  endtask

  task automatic mult64(input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp,
                        input string name, input bit poke);
    int  lat = 0;
    int  busy_obs = 0;
    int  extra = 0;
    bit  seen = 0;
    wait_ready(name);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    multiplicand = {$urandom, $urandom};
    multiplier   = {$urandom, $urandom};
    for (int k = 0; k < 200 && !seen; k++) begin
      if (done) seen = 1;
      else begin
        if (busy) busy_obs++;
        if (poke && k == 10) start = 1'b1;
        if (poke && k == 11) start = 1'b0;
        tick();
        lat++;
      end
    end
    check({name, "_done_timeout"}, 128'(seen), 128'd1);
    check({name, "_latency"}, 128'(lat), 128'd64);
    check({name, "_busy_cycles"}, 128'(busy_obs), 128'd64);
    check({name, "_product"}, product, exp);
    check({name, "_zero"}, 128'(zero), 128'(exp == 128'd0));
    check({name, "_ready_in_done"}, 128'(ready), 128'd1);
    tick();
    check({name, "_done_one_cycle"}, 128'(done), 128'd0);
    check({name, "_product_held"}, product, exp);
    if (poke) begin
      for (int k = 0; k < 70; k++) begin
        if (done) extra++;
        tick();
      end
      check({name, "_no_second_done"}, 128'(extra), 128'd0);
    end
  endtask

  task automatic mult4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                       input string name);
    int lat = 0;
    bit seen = 0;
    mcand4  = a;
    mplier4 = b;
    start4  = 1'b1;
    tick();
    start4  = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (done4) seen = 1;
      else begin
        tick();
        lat++;
      end
    end
    check({name, "_done_timeout"}, 128'(seen), 128'd1);
    check({name, "_latency"}, 128'(lat), 128'd4);
    check({name, "_product"}, 128'(product4), 128'(exp));
    check({name, "_zero"}, 128'(zero4), 128'(exp == 8'd0));
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat1, lat2, cnt;
    bit  seen;
    logic [63:0] ra, rb;

    vecs[0] = '{64'd3, 64'd5, 128'd15, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0};
    vecs[2] = '{64'h1234, 64'd0, 128'd0, 1'b1};
    vecs[3] = '{64'd7, 64'd6, 128'd42, 1'b0};
    vecs[4] = '{64'd2, 64'd9, 128'd18, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000, 1'b0};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[7] = '{64'h1_0000_0000, 64'h1_0000_0000, 128'h1_0000_0000_0000_0000, 1'b0};

    // Reset state
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    check("rst_ready", 128'(ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_product", product, 128'd0);
    check("rst_zero", 128'(zero), 128'd1);
    check("rst4_ready", 128'(ready4), 128'd1);
    check("rst4_product", 128'(product4), 128'd0);

    mult4(4'hF, 4'hF, 8'hE1, "w4_ff");

    for (int i = 0; i < 8; i++)
      mult64(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i), vecs[i].poke);

    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 4 == 1) ra = ra & 64'hFFFF;
      if (i % 4 == 2) rb = 64'd0;
      mult64(ra, rb, ref_mul(ra, rb), $sformatf("rnd%0d", i), 1'b0);
    end

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        mult4(4'(a), 4'(b), 8'(a * b), $sformatf("w4_%0d_%0d", a, b));

    // Back-to-back: start held through the DONE cycle
    wait_ready("b2b");
    multiplicand = 64'd7;
    multiplier   = 64'd6;
    start        = 1'b1;
    tick();
    multiplicand = 64'd2;
    multiplier   = 64'd9;
    lat1 = 0;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (done) seen = 1;
      else begin
        tick();
        lat1++;
      end
    end
    check("b2b_first_latency", 128'(lat1), 128'd64);
    check("b2b_first_product", product, 128'd42);
    tick();
    start = 1'b0;
    check("b2b_second_accepted", 128'(busy), 128'd1);
    lat2 = 1;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (done) seen = 1;
      else begin
        tick();
        lat2++;
      end
    end
    check("b2b_gap", 128'(lat2), 128'd65);
    check("b2b_second_product", product, 128'd18);
    tick();
    check("b2b_done_low", 128'(done), 128'd0);

    // Reset in the middle of an operation
    wait_ready("midrst");
    multiplicand = 64'd11;
    multiplier   = 64'd13;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_ready", 128'(ready), 128'd1);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    check("midrst_product", product, 128'd0);
    check("midrst_zero", 128'(zero), 128'd1);
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      if (done) cnt++;
      tick();
    end
    check("midrst_no_done", 128'(cnt), 128'd0);
    mult64(64'd3, 64'd5, 128'd15, "after_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
